// File: rtl/pin_frame_rx.sv
// Byte-stream framer for the pin UART receiver: SYNC, CMD, LEN, payload, XOR checksum.
// Reports good frames and aborts (checksum, length, inter-byte timeout) as one-cycle pulses.
module pin_frame_rx #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned MAX_LEN   = 16,
  parameter int unsigned TIMEOUT   = 1000,
  localparam int unsigned AW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    dato,
  input  logic          data_rcv,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic [7:0]    frame_cmd,
  output logic [7:0]    frame_len,
  output logic          frame_valid,
  output logic          frame_err,
  output logic [1:0]    err_code,
  output logic          busy
);

  localparam int unsigned   TW        = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TimerLast = TW'(TIMEOUT - 1);
  localparam logic [7:0]    MaxLen8   = 8'(MAX_LEN);
  localparam logic [AW:0]   MaxLenA   = (AW + 1)'(MAX_LEN);

  typedef enum logic [2:0] {StHunt, StCmd, StLen, StPayload, StChk} state_e;

  state_e        state_q, state_d;
  logic [7:0]    chk_q, chk_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [7:0]    len_q, len_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    frame_cmd_q, frame_cmd_d;
  logic [7:0]    frame_len_q, frame_len_d;
  logic          frame_valid_q, frame_valid_d;
  logic          frame_err_q, frame_err_d;
  logic [1:0]    err_code_q, err_code_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          mem_we;
  logic [7:0]    pl_mem_q [MAX_LEN];

  always_comb begin
    state_d       = state_q;
    chk_d         = chk_q;
    cmd_d         = cmd_q;
    len_d         = len_q;
    idx_d         = idx_q;
    frame_cmd_d   = frame_cmd_q;
    frame_len_d   = frame_len_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;
    err_code_d    = err_code_q;
    mem_we        = 1'b0;
    // Timer restarts on every byte and idles at zero while hunting.
    timer_d       = (state_q == StHunt || data_rcv) ? '0 : timer_q + TW'(1);

    if (data_rcv) begin
      unique case (state_q)
        StHunt: begin
          if (dato == SYNC_BYTE) begin
            state_d = StCmd;
            chk_d   = 8'h00;
          end
        end
        StCmd: begin
          cmd_d   = dato;
          chk_d   = dato;
          state_d = StLen;
        end
        StLen: begin
          if (dato > MaxLen8) begin
            frame_err_d = 1'b1;
            err_code_d  = 2'd2;
            state_d     = StHunt;
          end else begin
            len_d   = dato;
            chk_d   = chk_q ^ dato;
            idx_d   = '0;
            state_d = (dato == 8'h00) ? StChk : StPayload;
          end
        end
        StPayload: begin
          mem_we = 1'b1;
          chk_d  = chk_q ^ dato;
          idx_d  = idx_q + AW'(1);
          if (8'(idx_q) == len_q - 8'd1) state_d = StChk;
        end
        StChk: begin
          if (dato == chk_q) begin
            frame_valid_d = 1'b1;
            frame_cmd_d   = cmd_q;
            frame_len_d   = len_q;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = 2'd1;
          end
          state_d = StHunt;
        end
        default: state_d = StHunt;
      endcase
    end else if (state_q != StHunt && timer_q == TimerLast) begin
      frame_err_d = 1'b1;
      err_code_d  = 2'd3;
      state_d     = StHunt;
    end

    rd_data_d = ({1'b0, rd_addr} < MaxLenA) ? pl_mem_q[rd_addr] : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StHunt;
      chk_q         <= 8'h00;
      cmd_q         <= 8'h00;
      len_q         <= 8'h00;
      idx_q         <= '0;
      timer_q       <= '0;
      frame_cmd_q   <= 8'h00;
      frame_len_q   <= 8'h00;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      err_code_q    <= 2'd0;
      rd_data_q     <= 8'h00;
    end else begin
      state_q       <= state_d;
      chk_q         <= chk_d;
      cmd_q         <= cmd_d;
      len_q         <= len_d;
      idx_q         <= idx_d;
      timer_q       <= timer_d;
      frame_cmd_q   <= frame_cmd_d;
      frame_len_q   <= frame_len_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      err_code_q    <= err_code_d;
      rd_data_q     <= rd_data_d;
    end
  end

  // Payload storage carries no reset; only a new frame's payload overwrites it.
  always_ff @(posedge clk) begin
    if (mem_we) pl_mem_q[idx_q] <= dato;
  end

  assign rd_data     = rd_data_q;
  assign frame_cmd   = frame_cmd_q;
  assign frame_len   = frame_len_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign err_code    = err_code_q;
  assign busy        = (state_q != StHunt);

endmodule
